// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//
// Shares one SDRAM controller write channel and one read channel between two
// clients. Port 0 is the capture stream and port 1 is the host/readout path.
// Each channel has a round-robin arbiter with a bounded grant hold, so that
// consecutive beats from one port tend to stay in one open row. Read data is
// returned in order. A 1-bit port-tag FIFO records which port issued each
// outstanding read and steers the returned data back to that port.
//
// Optional build macro:
//   SDRAM_ARB_P0_PRIO_EN - the write channel uses fixed priority instead:
//                          port 0 wins whenever p0_wvalid is high. The read
//                          channel is unaffected.
//
// Ports:
//   clk, rst                      controller clock; synchronous active-high reset
//   pK_awaddr/wdata/wvalid/wready client write channel, K = 0, 1
//   pK_araddr/arvalid/arready     client read request channel
//   pK_rdata/rvalid               client read return (rdata is shared)
//   s_awaddr/wdata/wvalid/wready  controller write channel
//   s_araddr/arvalid/arready      controller read request channel
//   s_rdata/rvalid                controller read return
//   rd_err                        sticky flag: read data returned with no read outstanding
module sdram_port_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned RD_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] p0_awaddr,
  input  logic [15:0] p0_wdata,
  input  logic        p0_wvalid,
  output logic        p0_wready,
  input  logic [23:0] p0_araddr,
  input  logic        p0_arvalid,
  output logic        p0_arready,
  output logic [15:0] p0_rdata,
  output logic        p0_rvalid,
  input  logic [23:0] p1_awaddr,
  input  logic [15:0] p1_wdata,
  input  logic        p1_wvalid,
  output logic        p1_wready,
  input  logic [23:0] p1_araddr,
  input  logic        p1_arvalid,
  output logic        p1_arready,
  output logic [15:0] p1_rdata,
  output logic        p1_rvalid,
  output logic [23:0] s_awaddr,
  output logic [15:0] s_wdata,
  output logic        s_wvalid,
  input  logic        s_wready,
  output logic [23:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [15:0] s_rdata,
  input  logic        s_rvalid,
  output logic        rd_err
);

  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
  localparam int unsigned PW = $clog2(RD_DEPTH);
  localparam logic [HW-1:0] HoldOne = HW'(1);
  localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);
  localparam logic [PW:0]   CntFull = (PW + 1)'(RD_DEPTH);

  // Keep the current selection while it is requesting. Otherwise hand the
  // grant to the other port if that port is requesting.
  function automatic logic grant(input logic sel, input logic [1:0] valid);
    if (!valid[sel] && valid[~sel]) return ~sel;
    return sel;
  endfunction

  // Next {sel, hold}. hold counts consecutive beats accepted for sel. Once
  // MAX_HOLD beats have gone through while the other port waits, the grant
  // is handed over.
  function automatic logic [HW:0] arb_next(input logic sel, input logic [HW-1:0] hold,
                                           input logic [1:0] valid, input logic g,
                                           input logic hs);
    logic          sel_n;
    logic [HW-1:0] hold_n;
    logic [HW:0]   inc;
    sel_n  = sel;
    hold_n = hold;
    inc    = {1'b0, hold} + {1'b0, HoldOne};
    if (hs) begin
      if (g != sel) begin
        sel_n  = g;
        hold_n = HoldOne;
      end else if (valid[~sel] && (inc >= {1'b0, HoldMax})) begin
        sel_n  = ~sel;
        hold_n = '0;
      end else if (hold < HoldMax) begin
        hold_n = inc[HW-1:0];
      end
    end else if (!valid[sel]) begin
      hold_n = '0;
    end
    return {sel_n, hold_n};
  endfunction

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic [1:0] w_valid;
  logic       wg;
  logic       w_hs;

  assign w_valid = {p1_wvalid, p0_wvalid};

`ifdef SDRAM_ARB_P0_PRIO_EN
  // Fixed priority needs no arbitration state.
  assign wg = p0_wvalid ? 1'b0 : p1_wvalid;
`else
  logic          wsel_q, wsel_d;
  logic [HW-1:0] whold_q, whold_d;

  assign wg                 = grant(wsel_q, w_valid);
  assign {wsel_d, whold_d}  = arb_next(wsel_q, whold_q, w_valid, wg, w_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      wsel_q  <= 1'b0;
      whold_q <= '0;
    end else begin
      wsel_q  <= wsel_d;
      whold_q <= whold_d;
    end
  end
`endif

  assign s_awaddr  = wg ? p1_awaddr : p0_awaddr;
  assign s_wdata   = wg ? p1_wdata : p0_wdata;
  assign s_wvalid  = !rst && w_valid[wg];
  assign p0_wready = !rst && s_wready && !wg;
  assign p1_wready = !rst && s_wready && wg;
  assign w_hs      = s_wvalid && s_wready;

  // ---------------------------------------------------------------------------
  // Read request channel
  // ---------------------------------------------------------------------------
  logic [1:0]    r_valid;
  logic          rg;
  logic          r_hs;
  logic          rsel_q, rsel_d;
  logic [HW-1:0] rhold_q, rhold_d;
  logic          tag_full;
  logic          tag_empty;

  assign r_valid           = {p1_arvalid, p0_arvalid};
  assign rg                = grant(rsel_q, r_valid);
  assign {rsel_d, rhold_d} = arb_next(rsel_q, rhold_q, r_valid, rg, r_hs);

  // Full blocks new requests even if a pop happens in the same cycle. This
  // keeps the ready path independent of s_rvalid.
  assign s_araddr   = rg ? p1_araddr : p0_araddr;
  assign s_arvalid  = !rst && r_valid[rg] && !tag_full;
  assign p0_arready = !rst && s_arready && !tag_full && !rg;
  assign p1_arready = !rst && s_arready && !tag_full && rg;
  assign r_hs       = s_arvalid && s_arready;

  // ---------------------------------------------------------------------------
  // Port-tag FIFO and return routing
  // ---------------------------------------------------------------------------
  logic [RD_DEPTH-1:0] tag_mem_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         cnt_q, cnt_d;
  logic                rd_err_q, rd_err_d;
  logic                pop;
  logic                head;

  assign tag_full  = (cnt_q == CntFull);
  assign tag_empty = (cnt_q == '0);
  assign pop       = !rst && s_rvalid && !tag_empty;
  assign head      = tag_mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({r_hs, pop})
      2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign rd_err_d = rd_err_q || (s_rvalid && tag_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsel_q    <= 1'b0;
      rhold_q   <= '0;
      tag_mem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rsel_q   <= rsel_d;
      rhold_q  <= rhold_d;
      cnt_q    <= cnt_d;
      rd_err_q <= rd_err_d;
      if (r_hs) begin
        tag_mem_q[wr_ptr_q] <= rg;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign p0_rdata  = s_rdata;
  assign p1_rdata  = s_rdata;
  assign p0_rvalid = pop && !head;
  assign p1_rvalid = pop && head;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter. Stimulus pushes the expected
// write, read-request and read-return beats into queues. A negedge monitor
// pops an entry from the matching queue on each handshake or return and
// compares it with the DUT outputs.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] p0_awaddr, p1_awaddr, p0_araddr, p1_araddr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_wvalid, p1_wvalid, p0_arvalid, p1_arvalid;
  logic        p0_wready, p1_wready, p0_arready, p1_arready;
  logic [15:0] p0_rdata, p1_rdata;
  logic        p0_rvalid, p1_rvalid;
  logic [23:0] s_awaddr, s_araddr;
  logic [15:0] s_wdata, s_rdata;
  logic        s_wvalid, s_wready, s_arvalid, s_arready, s_rvalid;
  logic        rd_err;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .p0_awaddr  (p0_awaddr),
    .p0_wdata   (p0_wdata),
    .p0_wvalid  (p0_wvalid),
    .p0_wready  (p0_wready),
    .p0_araddr  (p0_araddr),
    .p0_arvalid (p0_arvalid),
    .p0_arready (p0_arready),
    .p0_rdata   (p0_rdata),
    .p0_rvalid  (p0_rvalid),
    .p1_awaddr  (p1_awaddr),
    .p1_wdata   (p1_wdata),
    .p1_wvalid  (p1_wvalid),
    .p1_wready  (p1_wready),
    .p1_araddr  (p1_araddr),
    .p1_arvalid (p1_arvalid),
    .p1_arready (p1_arready),
    .p1_rdata   (p1_rdata),
    .p1_rvalid  (p1_rvalid),
    .s_awaddr   (s_awaddr),
    .s_wdata    (s_wdata),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rvalid   (s_rvalid),
    .rd_err     (rd_err)
  );

  typedef struct packed {
    logic        port;
    logic [23:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        wexp[$];
  exp_t        arexp[$];
  exp_t        rexp[$];
  logic [39:0] wsrc0[$];
  logic [39:0] wsrc1[$];
  logic [23:0] rsrc0[$];
  logic [23:0] rsrc1[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        hs_w0 = 1'b0, hs_w1 = 1'b0, hs_r0 = 1'b0, hs_r1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic void expw(input logic port, input logic [23:0] a, input logic [15:0] d);
    wexp.push_back('{port: port, addr: a, data: d});
  endfunction

  function automatic void expar(input logic port, input logic [23:0] a);
    arexp.push_back('{port: port, addr: a, data: 16'h0});
  endfunction

  function automatic void expr(input logic port, input logic [15:0] d);
    rexp.push_back('{port: port, addr: 24'h0, data: d});
  endfunction

  // Monitor: every handshake or return must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("wready_exclusive", 32'(p0_wready && p1_wready), 32'd0);
      check("rvalid_exclusive", 32'(p0_rvalid && p1_rvalid), 32'd0);
      if (s_wvalid && s_wready) begin
        if (wexp.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = wexp.pop_front();
          check("w_port", 32'(p1_wready), 32'(e.port));
          check("w_addr", 32'(s_awaddr), 32'(e.addr));
          check("w_data", 32'(s_wdata), 32'(e.data));
        end
      end
      if (s_arvalid && s_arready) begin
        if (arexp.size() == 0) begin
          check("unexpected_read_req", 32'd1, 32'd0);
        end else begin
          e = arexp.pop_front();
          check("ar_port", 32'(p1_arready), 32'(e.port));
          check("ar_addr", 32'(s_araddr), 32'(e.addr));
        end
      end
      if (p0_rvalid || p1_rvalid) begin
        if (rexp.size() == 0) begin
          check("unexpected_return", 32'd1, 32'd0);
        end else begin
          e = rexp.pop_front();
          check("r_port", 32'(p1_rvalid), 32'(e.port));
          check("r_data0", 32'(p0_rdata), 32'(e.data));
          check("r_data1", 32'(p1_rdata), 32'(e.data));
        end
      end else if (s_rvalid && rexp.size() != 0) begin
        check("missing_return", 32'd0, 32'd1);
      end
    end
  end

  // Client models: present the head of each source queue and drop it once
  // it has been accepted.
  task automatic drive();
    p0_wvalid = (wsrc0.size() != 0);
    if (p0_wvalid) {p0_awaddr, p0_wdata} = wsrc0[0];
    p1_wvalid = (wsrc1.size() != 0);
    if (p1_wvalid) {p1_awaddr, p1_wdata} = wsrc1[0];
    p0_arvalid = (rsrc0.size() != 0);
    if (p0_arvalid) p0_araddr = rsrc0[0];
    p1_arvalid = (rsrc1.size() != 0);
    if (p1_arvalid) p1_araddr = rsrc1[0];
  endtask

  task automatic sample();
    @(negedge clk);
    hs_w0 = p0_wvalid && p0_wready;
    hs_w1 = p1_wvalid && p1_wready;
    hs_r0 = p0_arvalid && p0_arready;
    hs_r1 = p1_arvalid && p1_arready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (hs_w0) void'(wsrc0.pop_front());
    if (hs_w1) void'(wsrc1.pop_front());
    if (hs_r0) void'(rsrc0.pop_front());
    if (hs_r1) void'(rsrc1.pop_front());
    drive();
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  task automatic run_idle(input int budget, input string name);
    int n = 0;
    while ((wsrc0.size() + wsrc1.size() + rsrc0.size() + rsrc1.size()) != 0 && n < budget) begin
      cyc();
      n++;
    end
    check(name, 32'(wsrc0.size() + wsrc1.size() + rsrc0.size() + rsrc1.size()), 32'd0);
  endtask

  logic [15:0] rd_data [3] = '{16'hA1, 16'hB2, 16'hC3};

  initial begin
    // Reset with every request and ready asserted: all handshake outputs forced low.
    rst = 1'b1;
    p0_awaddr = '0; p1_awaddr = '0; p0_araddr = '0; p1_araddr = '0;
    p0_wdata = '0; p1_wdata = '0; s_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      p0_wvalid = 1'b1; p1_wvalid = 1'b1; p0_arvalid = 1'b1; p1_arvalid = 1'b1;
      s_wready = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1;
      sample();
      check("rst_p0_wready", 32'(p0_wready), 32'd0);
      check("rst_p1_wready", 32'(p1_wready), 32'd0);
      check("rst_p0_arready", 32'(p0_arready), 32'd0);
      check("rst_p1_arready", 32'(p1_arready), 32'd0);
      check("rst_s_wvalid", 32'(s_wvalid), 32'd0);
      check("rst_s_arvalid", 32'(s_arvalid), 32'd0);
      check("rst_rvalid", 32'(p0_rvalid || p1_rvalid), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; s_rvalid = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    drive();
    sample();
    check("idle_readies", 32'({p0_wready, p1_wready, p0_arready, p1_arready}), 32'd0);
    check("idle_s_wvalid", 32'(s_wvalid), 32'd0);
    check("idle_s_arvalid", 32'(s_arvalid), 32'd0);
    check("idle_rd_err", 32'(rd_err), 32'd0);
    step();

    // Write contention: both ports hold requests continuously.
    for (int i = 0; i < 16; i++) begin
      wsrc0.push_back({24'h100000 + 24'(i), 16'h0000 + 16'(i)});
      wsrc1.push_back({24'h200000 + 24'(i), 16'h1000 + 16'(i)});
    end
`ifdef SDRAM_ARB_P0_PRIO_EN
    for (int i = 0; i < 16; i++) expw(1'b0, 24'h100000 + 24'(i), 16'h0000 + 16'(i));
    for (int i = 0; i < 16; i++) expw(1'b1, 24'h200000 + 24'(i), 16'h1000 + 16'(i));
`else
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) begin
        if (b % 2 == 0) expw(1'b0, 24'h100000 + 24'((b / 2) * 8 + j), 16'h0000 + 16'((b / 2) * 8 + j));
        else            expw(1'b1, 24'h200000 + 24'((b / 2) * 8 + j), 16'h1000 + 16'((b / 2) * 8 + j));
      end
    end
`endif
    s_wready = 1'b1;
    drive();
    run_idle(100, "contention_drain");

    // Write backpressure on a lone port-1 request.
    s_wready = 1'b0;
    wsrc1.push_back({24'h2ABCDE, 16'h5A5A});
    expw(1'b1, 24'h2ABCDE, 16'h5A5A);
    drive();
    for (int c = 0; c < 5; c++) begin
      sample();
      check("bp_s_wvalid", 32'(s_wvalid), 32'd1);
      check("bp_s_awaddr", 32'(s_awaddr), 32'h2ABCDE);
      check("bp_s_wdata", 32'(s_wdata), 32'h5A5A);
      check("bp_p1_wready", 32'(p1_wready), 32'd0);
      step();
    end
    s_wready = 1'b1;
    run_idle(5, "bp_drain");

    // Read routing: p0, p1, p0 requests, then three in-order returns.
    s_arready = 1'b1;
    rsrc0.push_back(24'h000010); expar(1'b0, 24'h000010); drive(); run_idle(5, "rd_req0");
    rsrc1.push_back(24'h000800); expar(1'b1, 24'h000800); drive(); run_idle(5, "rd_req1");
    rsrc0.push_back(24'h000011); expar(1'b0, 24'h000011); drive(); run_idle(5, "rd_req2");
    expr(1'b0, 16'hA1); expr(1'b1, 16'hB2); expr(1'b0, 16'hC3);
    for (int i = 0; i < 3; i++) begin
      s_rdata = rd_data[i];
      s_rvalid = 1'b1;
      cyc();
    end
    s_rvalid = 1'b0;

    // Tag FIFO fill: 8 accepted, the ninth blocks.
    for (int i = 0; i < 9; i++) begin
      rsrc0.push_back(24'h000300 + 24'(i));
      expar(1'b0, 24'h000300 + 24'(i));
    end
    drive();
    for (int c = 0; c < 8; c++) cyc();
    for (int c = 0; c < 3; c++) begin
      sample();
      check("full_arready", 32'(p0_arready), 32'd0);
      check("full_s_arvalid", 32'(s_arvalid), 32'd0);
      step();
    end
    // A pop while full still blocks this cycle, then frees one slot.
    expr(1'b0, 16'h00D0);
    s_rdata = 16'h00D0;
    s_rvalid = 1'b1;
    sample();
    check("full_pop_arready", 32'(p0_arready), 32'd0);
    check("full_pop_s_arvalid", 32'(s_arvalid), 32'd0);
    step();
    s_rvalid = 1'b0;
    sample();
    check("after_pop_arready", 32'(p0_arready), 32'd1);
    step();
    // Drop to 7 outstanding, then push and pop together: count must stay 7.
    expr(1'b0, 16'h00D1);
    s_rdata = 16'h00D1;
    s_rvalid = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      rsrc0.push_back(24'h000400 + 24'(i));
      expar(1'b0, 24'h000400 + 24'(i));
    end
    expr(1'b0, 16'h00D2);
    s_rdata = 16'h00D2;
    drive();
    sample();
    check("pp_arready", 32'(p0_arready), 32'd1);
    step();
    s_rvalid = 1'b0;
    sample();
    check("pp_arready_second", 32'(p0_arready), 32'd1);
    step();
    sample();
    check("pp_full_again", 32'(p0_arready), 32'd0);
    step();
    // Drain: 8 outstanding, and 0x402 is accepted along the way, so 9 returns.
    for (int i = 0; i < 9; i++) begin
      expr(1'b0, 16'h00E0 + 16'(i));
      s_rdata = 16'h00E0 + 16'(i);
      s_rvalid = 1'b1;
      cyc();
    end
    s_rvalid = 1'b0;
    run_idle(2, "drain_sources");

    // Return with nothing outstanding.
    s_rdata = 16'h00EE;
    s_rvalid = 1'b1;
    sample();
    check("err_no_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("err_no_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("err_flag_before", 32'(rd_err), 32'd0);
    step();
    s_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check("err_sticky", 32'(rd_err), 32'd1);
      step();
    end
    // The FIFO count must not have underflowed.
    rsrc1.push_back(24'h000555); expar(1'b1, 24'h000555); drive(); run_idle(5, "post_err_req");
    expr(1'b1, 16'h00F5);
    s_rdata = 16'h00F5;
    s_rvalid = 1'b1;
    cyc();
    s_rvalid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sample();
    check("err_cleared", 32'(rd_err), 32'd0);
    step();

    check("wexp_left", 32'(wexp.size()), 32'd0);
    check("arexp_left", 32'(arexp.size()), 32'd0);
    check("rexp_left", 32'(rexp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
